// File: rtl/branch_cmp_ctrl.sv
// ID-stage branch comparator control: E/M/W write scoreboard, hazard stall,
// per-operand forwarding select, comparator B configuration and taken decision.
module branch_cmp_ctrl #(
  parameter int SAT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_is_br,
  input  logic [2:0]       id_br_type,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_wr,
  input  logic [4:0]       id_wa,
  input  logic [1:0]       id_tnew,
  input  logic             cmp_eq,
  input  logic             a_sign,
  output logic             stall,
  output logic             cmp_b_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             br_taken,
  output logic [SAT_W-1:0] stall_cnt
);

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLEZ = 3'd2;
  localparam logic [2:0] BR_BGTZ = 3'd3;
  localparam logic [2:0] BR_BLTZ = 3'd4;
  localparam logic [2:0] BR_BGEZ = 3'd5;

  // Scoreboard: _p0 = E, _p1 = M, _p2 = W.
  logic       vld_p0, vld_p1, vld_p2;
  logic [4:0] wa_p0, wa_p1, wa_p2;
  logic [1:0] tnew_p0, tnew_p1, tnew_p2;

  logic       use_a, use_b;
  logic [2:0] res_a, res_b;
  logic       a_not_ready, b_not_ready;
  logic       taken_raw;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] c);
    return (&c) ? c : c + {{(SAT_W-1){1'b0}}, 1'b1};
  endfunction

  // Returns {not_ready, fwd}; youngest matching producer wins.
  function automatic logic [2:0] lookup(
    input logic [4:0] src,
    input logic v0, input logic [4:0] a0, input logic [1:0] t0,
    input logic v1, input logic [4:0] a1, input logic [1:0] t1,
    input logic v2, input logic [4:0] a2, input logic [1:0] t2
  );
    if (src == 5'd0)            return 3'b000;
    else if (v0 && a0 == src)   return {(t0 != 2'd0), 2'd1};
    else if (v1 && a1 == src)   return {(t1 != 2'd0), 2'd2};
    else if (v2 && a2 == src)   return {(t2 != 2'd0), 2'd3};
    else                        return 3'b000;
  endfunction

  always_comb begin
    use_a     = !reset && id_valid && id_is_br;
    use_b     = use_a && (id_br_type < BR_BLEZ);
    res_a     = lookup(id_rs, vld_p0, wa_p0, tnew_p0, vld_p1, wa_p1, tnew_p1,
                       vld_p2, wa_p2, tnew_p2);
    res_b     = lookup(id_rt, vld_p0, wa_p0, tnew_p0, vld_p1, wa_p1, tnew_p1,
                       vld_p2, wa_p2, tnew_p2);
    a_not_ready = use_a && res_a[2];
    b_not_ready = use_b && res_b[2];
    stall     = a_not_ready || b_not_ready;
    fwd_a     = (use_a && !res_a[2]) ? res_a[1:0] : 2'd0;
    fwd_b     = (use_b && !res_b[2]) ? res_b[1:0] : 2'd0;
    cmp_b_sel = use_a && (id_br_type >= BR_BLEZ);
    // With B tied to zero, cmp_eq reports A==0.
    case (id_br_type)
      BR_BEQ:  taken_raw = cmp_eq;
      BR_BNE:  taken_raw = !cmp_eq;
      BR_BLEZ: taken_raw = a_sign || cmp_eq;
      BR_BGTZ: taken_raw = !a_sign && !cmp_eq;
      BR_BLTZ: taken_raw = a_sign;
      BR_BGEZ: taken_raw = !a_sign;
      default: taken_raw = 1'b0;
    endcase
    br_taken  = use_a && !stall && taken_raw;
  end

  // E -> M -> W valid bits and stall statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      vld_p0 <= !stall && id_valid && id_wr && (id_wa != 5'd0);
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // E -> M -> W destination and remaining latency; qualified by vld_pN
  always_ff @(posedge clk) begin
    wa_p0   <= id_wa;
    tnew_p0 <= id_tnew;
    wa_p1   <= wa_p0;
    tnew_p1 <= tnew_dec(tnew_p0);
    wa_p2   <= wa_p1;
    tnew_p2 <= tnew_dec(tnew_p1);
  end

endmodule

// File: tb/tb_branch_cmp_ctrl.sv
// Directed bench for branch_cmp_ctrl: driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_branch_cmp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_is_br, id_wr, cmp_eq, a_sign;
  logic [2:0] id_br_type;
  logic [4:0] id_rs, id_rt, id_wa;
  logic [1:0] id_tnew;
  logic       stall, cmp_b_sel, br_taken;
  logic [1:0] fwd_a, fwd_b;
  logic [7:0] stall_cnt;

  branch_cmp_ctrl #(.SAT_W(8)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_br(id_is_br),
    .id_br_type(id_br_type), .id_rs(id_rs), .id_rt(id_rt), .id_wr(id_wr),
    .id_wa(id_wa), .id_tnew(id_tnew), .cmp_eq(cmp_eq), .a_sign(a_sign),
    .stall(stall), .cmp_b_sel(cmp_b_sel), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .br_taken(br_taken), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         q_cyc[$];
  string      q_name[$];
  logic [6:0] q_exp[$];
  bit         q_chk[$];
  logic [7:0] q_cnt[$];
  int total = 0;
  int bad   = 0;

  task automatic push(input string name, input logic s, input logic [1:0] fa,
                      input logic [1:0] fb, input logic bs, input logic tk,
                      input bit cc, input logic [7:0] cn);
    q_cyc.push_back(cyc);
    q_name.push_back(name);
    q_exp.push_back({s, fa, fb, bs, tk});
    q_chk.push_back(cc);
    q_cnt.push_back(cn);
  endtask

  task automatic step_idle();
    @(posedge clk); #1;
    id_valid = 0; id_is_br = 0; id_br_type = 0; id_rs = 0; id_rt = 0;
    id_wr = 0; id_wa = 0; id_tnew = 0; cmp_eq = 0; a_sign = 0;
  endtask

  task automatic step_nb(input logic [4:0] wa, input logic [1:0] tn, input logic [4:0] rs);
    @(posedge clk); #1;
    id_valid = 1; id_is_br = 0; id_br_type = 0; id_rs = rs; id_rt = 0;
    id_wr = 1; id_wa = wa; id_tnew = tn; cmp_eq = 0; a_sign = 0;
  endtask

  task automatic step_br(input logic [2:0] ty, input logic [4:0] rs, input logic [4:0] rt,
                         input logic eq, input logic sg);
    @(posedge clk); #1;
    id_valid = 1; id_is_br = 1; id_br_type = ty; id_rs = rs; id_rt = rt;
    id_wr = 0; id_wa = 0; id_tnew = 0; cmp_eq = eq; a_sign = sg;
  endtask

  logic [6:0] act, want;
  int         e_cyc;
  string      e_name;
  bit         e_chk;
  logic [7:0] e_cnt;

  always @(negedge clk) begin
    act = {stall, fwd_a, fwd_b, cmp_b_sel, br_taken};
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      e_cyc = q_cyc.pop_front(); e_name = q_name.pop_front(); want = q_exp.pop_front();
      e_chk = q_chk.pop_front(); e_cnt = q_cnt.pop_front();
      total++;
      if (e_cyc != cyc) begin
        bad++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e_name, e_cyc, cyc);
      end else if (act !== want || (e_chk && stall_cnt !== e_cnt)) begin
        bad++;
        $display("FAIL %s: got stall=%b fwd_a=%0d fwd_b=%0d b_sel=%b taken=%b cnt=%0d; want stall=%b fwd_a=%0d fwd_b=%0d b_sel=%b taken=%b cnt=%0d",
                 e_name, act[6], act[5:4], act[3:2], act[1], act[0], stall_cnt,
                 want[6], want[5:4], want[3:2], want[1], want[0], e_chk ? int'(e_cnt) : -1);
      end
    end
  end

  initial begin
    reset = 1;
    id_valid = 0; id_is_br = 0; id_br_type = 0; id_rs = 0; id_rt = 0;
    id_wr = 0; id_wa = 0; id_tnew = 0; cmp_eq = 0; a_sign = 0;
    repeat (2) @(posedge clk);
    // bgez that would be taken, but reset must hold every output low
    #1; id_valid = 1; id_is_br = 1; id_br_type = 3'd5; id_rs = 5; a_sign = 0;
    push("reset_outputs", 0, 0, 0, 0, 0, 1, 8'd0);

    // reset mid-stall
    step_nb(5'd8, 2'd2, 5'd0); reset = 0;
    push("rst_lw_issue", 0, 0, 0, 0, 0, 1, 8'd0);
    step_br(3'd0, 5'd8, 5'd9, 0, 0);
    push("rst_stall", 1, 0, 0, 0, 0, 1, 8'd0);
    step_br(3'd0, 5'd8, 5'd9, 0, 0); reset = 1;
    push("rst_asserted", 0, 0, 0, 0, 0, 1, 8'd0);
    step_br(3'd0, 5'd8, 5'd9, 0, 0); reset = 0;
    push("rst_released", 0, 0, 0, 0, 0, 1, 8'd0);

    // ALU hazard
    step_nb(5'd8, 2'd1, 5'd0);
    push("alu_issue", 0, 0, 0, 0, 0, 1, 8'd0);
    step_br(3'd0, 5'd8, 5'd9, 1, 0);
    push("alu_stall", 1, 0, 0, 0, 0, 1, 8'd0);
    step_br(3'd0, 5'd8, 5'd9, 1, 0);
    push("alu_fwd_m", 0, 2, 0, 0, 1, 1, 8'd1);

    // load hazard
    step_nb(5'd8, 2'd2, 5'd0);
    push("ld_issue", 0, 0, 0, 0, 0, 1, 8'd1);
    step_br(3'd1, 5'd8, 5'd0, 0, 0);
    push("ld_stall1", 1, 0, 0, 0, 0, 1, 8'd1);
    step_br(3'd1, 5'd8, 5'd0, 0, 0);
    push("ld_stall2", 1, 0, 0, 0, 0, 1, 8'd2);
    step_br(3'd1, 5'd8, 5'd0, 0, 0);
    push("ld_fwd_w", 0, 3, 0, 0, 1, 1, 8'd3);

    // single-operand and reserved branches, no hazards
    step_br(3'd3, 5'd5, 5'd0, 0, 0); push("bgtz_pos",   0, 0, 0, 1, 1, 1, 8'd3);
    step_br(3'd3, 5'd5, 5'd0, 1, 0); push("bgtz_zero",  0, 0, 0, 1, 0, 1, 8'd3);
    step_br(3'd4, 5'd5, 5'd0, 0, 1); push("bltz_neg",   0, 0, 0, 1, 1, 1, 8'd3);
    step_br(3'd2, 5'd5, 5'd0, 1, 0); push("blez_zero",  0, 0, 0, 1, 1, 1, 8'd3);
    step_br(3'd5, 5'd5, 5'd0, 0, 1); push("bgez_neg",   0, 0, 0, 1, 0, 1, 8'd3);
    step_br(3'd5, 5'd5, 5'd0, 1, 0); push("bgez_zero",  0, 0, 0, 1, 1, 1, 8'd3);
    step_br(3'd6, 5'd5, 5'd0, 1, 0); push("reserved6",  0, 0, 0, 1, 0, 1, 8'd3);
    step_br(3'd1, 5'd5, 5'd5, 1, 0); push("bne_equal",  0, 0, 0, 0, 0, 1, 8'd3);

    // priority (E over W) and independent rt hazard in M
    step_nb(5'd8, 2'd0, 5'd0); push("pri_w8",  0, 0, 0, 0, 0, 1, 8'd3);
    step_nb(5'd9, 2'd2, 5'd0); push("pri_m9",  0, 0, 0, 0, 0, 1, 8'd3);
    step_nb(5'd8, 2'd0, 5'd9); push("nonbr_no_stall", 0, 0, 0, 0, 0, 1, 8'd3);
    step_br(3'd0, 5'd8, 5'd9, 1, 0); push("pri_e_rt_stall", 1, 1, 0, 0, 0, 1, 8'd3);
    step_br(3'd0, 5'd8, 5'd9, 1, 0); push("pri_resolved",   0, 2, 3, 0, 1, 1, 8'd4);

    // saturation: 150 load-use pairs = 300 stall cycles
    for (int i = 0; i < 150; i++) begin
      step_nb(5'd10, 2'd2, 5'd0);     push("sat_issue",  0, 0, 0, 0, 0, 0, 8'd0);
      step_br(3'd4, 5'd10, 5'd0, 0, 1); push("sat_stall1", 1, 0, 0, 1, 0, 0, 8'd0);
      step_br(3'd4, 5'd10, 5'd0, 0, 1); push("sat_stall2", 1, 0, 0, 1, 0, 0, 8'd0);
      step_br(3'd4, 5'd10, 5'd0, 0, 1); push("sat_fwd_w",  0, 3, 0, 1, 1, 0, 8'd0);
    end
    step_idle(); push("sat_hold_ff", 0, 0, 0, 0, 0, 1, 8'hFF);

    repeat (3) @(posedge clk);
    #1;
    while (q_cyc.size() > 0) begin
      void'(q_cyc.pop_front()); e_name = q_name.pop_front();
      void'(q_exp.pop_front()); void'(q_chk.pop_front()); void'(q_cnt.pop_front());
      total++; bad++;
      $display("FAIL %s: expectation never checked, want checked", e_name);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
